traffic_queue_sensor: RTL and testbench

Vehicle-queue sensor model for the two-street intersection: the sensing side of the light/sensor interface. It counts vehicles arriving on street A and street B and releases them at a fixed rate while that street's light is green. It drives the traffic-present flags TA/TB to the light controller and consumes the controller's LA/LB light codes. It also flags illegal light combinations, so it serves both as the plant model in system simulation and as the sensor front end on hardware.

---
 rtl/traffic_queue_sensor.sv | 117 +++++++++++
 tb/tb_traffic_queue_sensor.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/traffic_queue_sensor.sv
// Two-street vehicle queue sensor: counts arrivals, releases one vehicle per
// DEPART_CYCLES of green, and latches illegal light combinations.

module traffic_queue_lane #(
  parameter int CNT_W         = 4,
  parameter int DEPART_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_arrive,
  input  logic             i_green,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);
  localparam int TMR_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

  logic [TMR_W-1:0] r_tmr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_active, w_last, w_dep, w_full;

  assign w_active = i_green && (r_count != '0);
  assign w_last   = (r_tmr == TMR_W'(DEPART_CYCLES - 1));
  assign w_dep    = w_active && w_last;
  assign w_full   = &r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Partial intervals are discarded whenever green drops or the queue empties.
      if (!w_active || w_last) r_tmr <= '0;
      else                     r_tmr <= r_tmr + 1'b1;

      unique case ({i_arrive, w_dep})
        2'b10: begin
          if (w_full) r_overflow <= 1'b1;
          else        r_count    <= r_count + 1'b1;
        end
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_overflow;
endmodule

module traffic_queue_sensor #(
  parameter int CNT_W         = 4,
  parameter int DEPART_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arrive_a,
  input  logic             arrive_b,
  input  logic [1:0]       LA,
  input  logic [1:0]       LB,
  output logic             TA,
  output logic             TB,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic             overflow_a,
  output logic             overflow_b,
  output logic             light_fault
);
  localparam logic [1:0] GREEN = 2'b00;
  localparam logic [1:0] RED   = 2'b10;
  localparam logic [1:0] BAD   = 2'b11;

  logic                        r_fault;
  logic                        w_fault_now;
  logic [1:0]                  w_arrive;
  logic [1:0][1:0]             w_light;
  logic [1:0]                  w_green;
  logic [1:0][CNT_W-1:0]       w_count;
  logic [1:0]                  w_ovf;

  assign w_arrive = {arrive_b, arrive_a};
  assign w_light  = {LB, LA};

  // Both non-red at once covers green/green, green/yellow and yellow/yellow.
  assign w_fault_now = (LA == BAD) || (LB == BAD) || ((LA != RED) && (LB != RED));

  always_ff @(posedge clk) begin
    if (reset) r_fault <= 1'b0;
    else       r_fault <= r_fault | w_fault_now;
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    assign w_green[g] = (w_light[g] == GREEN) && !r_fault;

    traffic_queue_lane #(
      .CNT_W        (CNT_W),
      .DEPART_CYCLES(DEPART_CYCLES)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_arrive  (w_arrive[g]),
      .i_green   (w_green[g]),
      .o_count   (w_count[g]),
      .o_overflow(w_ovf[g])
    );
  end

  assign count_a     = w_count[0];
  assign count_b     = w_count[1];
  assign TA          = (w_count[0] != '0);
  assign TB          = (w_count[1] != '0);
  assign overflow_a  = w_ovf[0];
  assign overflow_b  = w_ovf[1];
  assign light_fault = r_fault;
endmodule

// File: tb/tb_traffic_queue_sensor.sv
// Scoreboarded random bench for traffic_queue_sensor: driver predicts each
// cycle's post-edge outputs from a run-length model, monitor compares them.

module tb_traffic_queue_sensor;
  localparam int CNT_W = 4;
  localparam int DC    = 4;
  localparam int QMAX  = (1 << CNT_W) - 1;
  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, X = 2'b11;

  typedef struct packed {
    logic [CNT_W-1:0] ca;
    logic [CNT_W-1:0] cb;
    logic ta, tb, oa, ob, lf;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0, arrive_a = 1'b0, arrive_b = 1'b0;
  logic [1:0] LA = R, LB = R;
  logic TA, TB, overflow_a, overflow_b, light_fault;
  logic [CNT_W-1:0] count_a, count_b;

  traffic_queue_sensor #(.CNT_W(CNT_W), .DEPART_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .arrive_a(arrive_a), .arrive_b(arrive_b),
    .LA(LA), .LB(LB), .TA(TA), .TB(TB), .count_a(count_a), .count_b(count_b),
    .overflow_a(overflow_a), .overflow_b(overflow_b), .light_fault(light_fault)
  );

  always #5 clk = ~clk;

  obs_t sb[$];
  int   tests = 0, fails = 0, cyc = 0;

  // Model: a vehicle leaves each time a street has been green with a
  // non-empty queue for another full DC consecutive cycles.
  int m_cnt[2], m_run[2];
  bit m_ovf[2], m_fault;

  task automatic step(input bit rst, input bit aa, input bit ab,
                      input logic [1:0] la, input logic [1:0] lb);
    bit arr[2], dep, elig, bad;
    logic [1:0] lt[2];
    obs_t e;
    @(negedge clk);
    reset = rst; arrive_a = aa; arrive_b = ab; LA = la; LB = lb;
    arr[0] = aa; arr[1] = ab; lt[0] = la; lt[1] = lb;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_run[i] = 0; m_ovf[i] = 0; end
      m_fault = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        elig = (lt[i] == G) && !m_fault && (m_cnt[i] > 0);
        m_run[i] = elig ? m_run[i] + 1 : 0;
        dep = elig && (m_run[i] % DC == 0);
        if (arr[i] && !dep) begin
          if (m_cnt[i] == QMAX) m_ovf[i] = 1;
          else m_cnt[i]++;
        end else if (dep && !arr[i]) m_cnt[i]--;
      end
      bad = (la == X) || (lb == X) || ((la != R) && (lb != R));
      if (bad) m_fault = 1;
    end
    e.ca = m_cnt[0][CNT_W-1:0]; e.cb = m_cnt[1][CNT_W-1:0];
    e.ta = m_cnt[0] != 0; e.tb = m_cnt[1] != 0;
    e.oa = m_ovf[0]; e.ob = m_ovf[1]; e.lf = m_fault;
    sb.push_back(e);
    cyc++;
  endtask

  obs_t mon_e, mon_a;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_a = '{count_a, count_b, TA, TB, overflow_a, overflow_b, light_fault};
      tests++;
      if (mon_a !== mon_e) begin
        fails++;
        $display("FAIL state t=%0t got ca=%0d cb=%0d ta=%b tb=%b oa=%b ob=%b lf=%b, want ca=%0d cb=%0d ta=%b tb=%b oa=%b ob=%b lf=%b",
                 $time, mon_a.ca, mon_a.cb, mon_a.ta, mon_a.tb, mon_a.oa, mon_a.ob, mon_a.lf,
                 mon_e.ca, mon_e.cb, mon_e.ta, mon_e.tb, mon_e.oa, mon_e.ob, mon_e.lf);
      end
    end
  end

  initial begin
    logic [1:0] la, lb;
    int r, len, pa, pb;
    // Directed scenarios
    step(1, 0, 0, R, R);
    repeat (3) step(0, 1, 0, R, G);
    repeat (20) step(0, 0, 0, R, G);
    repeat (14) step(0, 0, 0, G, R);
    repeat (2) step(0, 1, 0, R, R);
    repeat (6) step(0, 0, 0, Y, R);
    repeat (17) step(0, 0, 1, R, R);
    repeat (9) step(0, 0, 1, R, G);
    step(1, 0, 0, R, R);
    repeat (2) step(0, 1, 0, R, R);
    repeat (10) step(0, 1, 0, G, R);
    repeat (2) step(0, 1, 1, G, R);
    step(0, 0, 0, G, Y);
    repeat (10) step(0, 0, 0, G, R);
    step(1, 0, 0, G, R);
    repeat (3) step(0, 1, 0, R, R);
    step(0, 0, 0, X, R);
    repeat (3) step(0, 0, 0, G, R);
    step(1, 0, 0, R, R);
    repeat (3) step(0, 1, 0, R, R);
    repeat (2) step(0, 0, 0, G, R);
    step(1, 1, 1, G, R);
    repeat (2) step(0, 1, 0, R, R);
    repeat (10) step(0, 0, 0, G, R);
    // Random phases
    while (cyc < 3500) begin
      r = $urandom_range(0, 99);
      len = $urandom_range(1, 16);
      pa = $urandom_range(0, 100); pb = $urandom_range(0, 100);
      if (r < 6 || (m_fault && r < 30)) begin
        step(1, $urandom_range(0, 1), $urandom_range(0, 1), G, R);
        continue;
      end else if (r < 9) begin
        la = 2'($urandom_range(0, 3)); lb = 2'($urandom_range(0, 3));
        len = 1;
      end else begin
        case ($urandom_range(0, 4))
          0: begin la = G; lb = R; end
          1: begin la = Y; lb = R; end
          2: begin la = R; lb = G; end
          3: begin la = R; lb = Y; end
          default: begin la = R; lb = R; end
        endcase
      end
      repeat (len)
        step(0, $urandom_range(0, 99) < pa, $urandom_range(0, 99) < pb, la, lb);
    end
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
